// File: rtl/irq_arbiter.sv
// Round-robin interrupt arbiter between level-request peripherals and the core.
// Grants one masked source at a time and pulses its completion line on mret.
module irq_arbiter #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] int_req_i,
    input  logic [N_SRC-1:0] int_mask_i,
    output logic [N_SRC-1:0] int_fin_o,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    input  logic             irq_ret_i,
    output logic [1:0]       state_dbg
);

    // Handshake: a source holds int_req_i[k] high until it sees int_fin_o[k]
    // high for one cycle, then drops the request on the following clock.
    // irq_o stays high from grant until the core's one-cycle irq_ret_i pulse.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IRQ  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam logic [3:0] LAST = 4'(N_SRC - 1);

    logic [1:0]       state, state_nxt;
    logic [3:0]       id, id_nxt;
    logic [3:0]       ptr, ptr_nxt;
    logic [3:0]       winner;
    logic             found;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] fin_nxt;
    logic [31:0]      cause_nxt;

    assign pend      = int_req_i & int_mask_i;
    assign state_dbg = state;

    // Round-robin: first pass covers ptr..N_SRC-1, second pass wraps to 0..ptr-1.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < N_SRC; j++) begin
            if (!found && pend[j] && (4'(j) >= ptr)) begin
                winner = 4'(j);
                found  = 1'b1;
            end
        end
        for (int j = 0; j < N_SRC; j++) begin
            if (!found && pend[j]) begin
                winner = 4'(j);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|pend) begin
                    state_nxt = IRQ;
                    id_nxt    = winner;
                end
            end
            IRQ: begin
                if (irq_ret_i) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
                ptr_nxt   = (id == LAST) ? 4'd0 : id + 4'd1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state register.
    always_comb begin
        fin_nxt = '0;
        for (int j = 0; j < N_SRC; j++) begin
            fin_nxt[j] = (state_nxt == ACK) && (id_nxt == 4'(j));
        end
        cause_nxt = (state_nxt == IRQ) ? (32'h8000_0010 + {28'd0, id_nxt}) : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            id          <= 4'd0;
            ptr         <= 4'd0;
            irq_o       <= 1'b0;
            irq_cause_o <= 32'd0;
            int_fin_o   <= '0;
        end else begin
            state       <= state_nxt;
            id          <= id_nxt;
            ptr         <= ptr_nxt;
            irq_o       <= (state_nxt == IRQ);
            irq_cause_o <= cause_nxt;
            int_fin_o   <= fin_nxt;
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios plus randomized traffic checked
// against a round-robin reference model of pending sources and pointer.
module tb_irq_arbiter;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] int_req_i;
    logic [N-1:0] int_mask_i;
    logic [N-1:0] int_fin_o;
    logic         irq_o;
    logic [31:0]  irq_cause_o;
    logic         irq_ret_i;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    irq_arbiter #(.N_SRC(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .int_req_i  (int_req_i),
        .int_mask_i (int_mask_i),
        .int_fin_o  (int_fin_o),
        .irq_o      (irq_o),
        .irq_cause_o(irq_cause_o),
        .irq_ret_i  (irq_ret_i),
        .state_dbg  (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: scan sources starting at the pointer, wrapping modulo N.
    function automatic int pick(input logic [N-1:0] p, input int ptr);
        logic [2:0] s;
        for (int k = 0; k < N; k++) begin
            s = 3'((ptr + k) % N);
            if (p[s]) return int'(s);
        end
        return -1;
    endfunction

    function automatic logic [31:0] cause_of(input int src);
        return 32'h8000_0010 + 32'(src);
    endfunction

    // One full interrupt: grant, handler of hlen cycles, mret, completion.
    task automatic serve(input int hlen, input logic [N-1:0] add_req, input bit clr_mask,
                         input bit early_ret, input bit ret_in_ack, input int want);
        int           exp_id;
        int           waited;
        logic [N-1:0] one_hot;
        exp_id = pick(int_req_i & int_mask_i, m_ptr);
        if (early_ret) irq_ret_i = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
            irq_ret_i = 1'b0;
        end while (!irq_o && waited < 40);
        chk("grant_latency", 32'(waited), 32'd1);
        chk("grant_cause", irq_cause_o, cause_of(exp_id));
        if (want >= 0) chk("grant_order", irq_cause_o, cause_of(want));
        if (clr_mask) int_mask_i = '0;
        int_req_i = int_req_i | add_req;
        for (int h = 0; h < hlen; h++) begin
            tick();
            chk("irq_hold", 32'(irq_o), 32'd1);
            chk("cause_hold", irq_cause_o, cause_of(exp_id));
        end
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = ret_in_ack;
        one_hot = N'(1) << exp_id;
        chk("fin_pulse", 32'(int_fin_o), 32'(one_hot));
        chk("irq_fall", 32'(irq_o), 32'd0);
        chk("cause_clear", irq_cause_o, 32'd0);
        int_req_i = int_req_i & ~one_hot;
        tick();
        irq_ret_i = 1'b0;
        chk("fin_single", 32'(int_fin_o), 32'd0);
        chk("irq_gap", 32'(irq_o), 32'd0);
        m_ptr = (exp_id + 1) % N;
    endtask

    initial begin
        logic [2:0] b;
        reset      = 1'b1;
        int_req_i  = '0;
        int_mask_i = '0;
        irq_ret_i  = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("reset_irq", 32'(irq_o), 32'd0);
        chk("reset_cause", irq_cause_o, 32'd0);
        chk("reset_fin", 32'(int_fin_o), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        m_ptr = 0;

        // Single source
        int_mask_i = 8'hFF;
        int_req_i  = 8'h08;
        serve(2, '0, 1'b0, 1'b0, 1'b0, 3);

        // Round-robin, twice, second time wrapping from ptr=3
        int_req_i = 8'h05;
        serve(1, '0, 1'b0, 1'b0, 1'b0, 0);
        serve(0, '0, 1'b0, 1'b0, 1'b0, 2);
        int_req_i = 8'h05;
        serve(1, '0, 1'b0, 1'b0, 1'b0, 0);
        serve(2, '0, 1'b0, 1'b0, 1'b0, 2);

        // Wrap-around after source 7
        int_req_i = 8'h80;
        serve(1, '0, 1'b0, 1'b0, 1'b0, 7);
        int_req_i = 8'h81;
        serve(1, '0, 1'b0, 1'b0, 1'b0, 0);
        serve(1, '0, 1'b0, 1'b0, 1'b0, 7);

        // Masking, then mask cleared mid-service
        int_req_i  = 8'h10;
        int_mask_i = 8'h00;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("masked_quiet", 32'(irq_o), 32'd0);
        end
        int_mask_i = 8'h10;
        serve(2, '0, 1'b1, 1'b0, 1'b0, 4);
        int_mask_i = 8'hFF;

        // Stray return in IDLE
        int_req_i = '0;
        irq_ret_i = 1'b1;
        tick();
        irq_ret_i = 1'b0;
        chk("stray_fin", 32'(int_fin_o), 32'd0);
        chk("stray_irq", 32'(irq_o), 32'd0);
        tick();
        chk("stray_fin2", 32'(int_fin_o), 32'd0);

        // Return held into ACK; return coinciding with the grant edge
        int_req_i = 8'h02;
        serve(1, '0, 1'b0, 1'b0, 1'b1, 1);
        int_req_i = 8'h09;
        serve(1, '0, 1'b0, 1'b1, 1'b0, 3);

        // Reset mid-service of source 5 with ptr=1 beforehand
        int_req_i = 8'h01;
        serve(0, '0, 1'b0, 1'b0, 1'b0, 0);
        int_req_i = 8'h20;
        tick();
        chk("pre_reset_irq", 32'(irq_o), 32'd1);
        chk("pre_reset_cause", irq_cause_o, cause_of(5));
        #2 reset = 1'b0;
        #1;
        chk("async_reset_irq", 32'(irq_o), 32'd0);
        chk("async_reset_cause", irq_cause_o, 32'd0);
        chk("async_reset_fin", 32'(int_fin_o), 32'd0);
        tick();
        reset = 1'b1;
        m_ptr = 0;
        chk("post_reset_fin", 32'(int_fin_o), 32'd0);
        int_req_i = 8'h21;
        serve(1, '0, 1'b0, 1'b0, 1'b0, 0);
        serve(1, '0, 1'b0, 1'b0, 1'b0, 5);

        // Randomized traffic against the reference model
        for (int it = 0; it < 25; it++) begin
            int_req_i  = int_req_i | N'($urandom_range(0, 255));
            int_mask_i = N'($urandom_range(0, 255));
            if ((int_req_i & int_mask_i) == '0) begin
                b = 3'($urandom_range(0, N - 1));
                int_req_i[b]  = 1'b1;
                int_mask_i[b] = 1'b1;
            end
            serve($urandom_range(0, 4),
                  N'($urandom_range(0, 255)) & N'($urandom_range(0, 255)),
                  $urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 3) == 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
